// File: rtl/regbank_pkg.sv
// Shared constants and read-FSM state type for the register-bank responder.
package regbank_pkg;
  localparam int          DATA_W     = 32;
  localparam int          NREGS      = 16;
  localparam logic [3:0]  REG_PC     = 4'd15;
  localparam logic [31:0] CPSR_RESET = 32'h000000D3;

  typedef enum logic [1:0] {IDLE, LOOK, RESP} rdState_t;
endpackage

// File: rtl/regbank_sync_responder_toggle_sync_edge.sv
// Toggle-request synchroniser: STAGES flops then XOR with a history flop.
// edgePulse is high for one cycle per input edge, STAGES cycles after the toggle.
module toggle_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic toggleIn,
  output logic edgePulse
);
  logic [STAGES-1:0] syncQ;
  logic              histQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncQ <= '0;
      histQ <= 1'b0;
    end else begin
      syncQ <= {syncQ[STAGES-2:0], toggleIn};
      histQ <= syncQ[STAGES-1];
    end
  end

  assign edgePulse = syncQ[STAGES-1] ^ histQ;
endmodule

// File: rtl/regbank_sync_responder.sv
// Register bank r0-r15 + CPSR answering toggle-signalled reads (2 cycles event->readyOut)
// and writes (ackW toggles the cycle after the write lands). Build option: REGBANK_FWD_EN.
module regbank_sync_responder
  import regbank_pkg::*;
#(
  parameter int          DATA_W      = regbank_pkg::DATA_W,
  parameter int          NREGS       = regbank_pkg::NREGS,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] CPSR_RESET  = regbank_pkg::CPSR_RESET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              triggerInr,
  input  logic [31:0]       addrr,
  output logic              readyOut,
  output logic [DATA_W-1:0] dataOut,
  input  logic              triggerInw,
  input  logic [31:0]       addrw,
  input  logic [DATA_W-1:0] dataIn,
  output logic              ackW,
  input  logic [DATA_W-1:0] pcIn,
  input  logic              pcWe,
  output logic [DATA_W-1:0] pcOut,
  input  logic [DATA_W-1:0] cpsrIn,
  input  logic              cpsrWe,
  output logic [DATA_W-1:0] cpsrOut
);
  localparam int IDX_W = $clog2(NREGS);
  localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(REG_PC);

  logic              evR, evW;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] cpsrQ;
  logic [DATA_W-1:0] lookData;
  logic [IDX_W-1:0]  rdIdx, wrIdx;
  logic              pendR, ackPend, pcLoad;
  rdState_t          state;
  logic              unusedAddr;

  // Upper address bits are architecturally don't-care.
  assign unusedAddr = ^{addrr[31:IDX_W], addrw[31:IDX_W]};
  assign wrIdx      = addrw[IDX_W-1:0];
  assign pcLoad     = pcWe && !(evW && wrIdx == PC_IDX);

  toggle_sync_edge #(.STAGES(SYNC_STAGES)) uSyncR (
    .clk(clk), .reset(reset), .toggleIn(triggerInr), .edgePulse(evR)
  );
  toggle_sync_edge #(.STAGES(SYNC_STAGES)) uSyncW (
    .clk(clk), .reset(reset), .toggleIn(triggerInw), .edgePulse(evW)
  );

  always_comb begin
    lookData = regs[rdIdx];
`ifdef REGBANK_FWD_EN
    if (evW && wrIdx == rdIdx)
      lookData = dataIn;
    else if (pcLoad && rdIdx == PC_IDX)
      lookData = pcIn;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      cpsrQ   <= DATA_W'(CPSR_RESET);
      ackPend <= 1'b0;
      ackW    <= 1'b0;
    end else begin
      if (evW)    regs[wrIdx]  <= dataIn;
      if (pcLoad) regs[PC_IDX] <= pcIn;
      if (cpsrWe) cpsrQ        <= cpsrIn;
      ackPend <= evW;
      if (ackPend) ackW <= ~ackW;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pendR    <= 1'b0;
      rdIdx    <= '0;
      dataOut  <= '0;
      readyOut <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          readyOut <= 1'b0;
          if (evR || pendR) begin
            rdIdx <= addrr[IDX_W-1:0];
            state <= LOOK;
            pendR <= pendR & evR;  // one of two coincident requests stays queued
          end
        end
        LOOK: begin
          dataOut  <= lookData;
          readyOut <= 1'b1;
          state    <= RESP;
          if (evR) pendR <= 1'b1;
        end
        RESP: begin
          readyOut <= 1'b0;
          state    <= IDLE;
          if (evR) pendR <= 1'b1;
        end
        default: begin
          readyOut <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign pcOut   = regs[PC_IDX];
  assign cpsrOut = cpsrQ;
endmodule

// File: doc/regbank_sync_responder.md
Name: regbank_sync_responder

Overview:
Clocked responder for the register-bank read/write protocol used by decode (read requester) and writeback (write requester). Requests arrive as toggle-signalled triggers with an address. The block synchronises each trigger, detects the toggle, then performs the access. Reads are answered with data plus a one-cycle readyOut pulse; writes are acknowledged with a toggle. It holds r0–r15 (r15 = PC) and the CPSR, and exposes PC/CPSR side ports to fetch and execute.

Parameters:
DATA_W, 32, register data width
NREGS, 16, number of architectural registers; index = addr[3:0]
SYNC_STAGES, 2, synchroniser depth on triggerInr/triggerInw (minimum 2)
CPSR_RESET, 32'h000000D3, CPSR value after reset

Ports:
clk  in  1  block clock
reset  in  1  asynchronous active-low reset
triggerInr  in  1  read request toggle; each edge (rise or fall) is one request
addrr  in  32  read address; only [3:0] used
readyOut  out  1  one-cycle pulse: dataOut valid for the current read
dataOut  out  DATA_W  read data; held until the next read response
triggerInw  in  1  write request toggle
addrw  in  32  write address; only [3:0] used
dataIn  in  DATA_W  write data
ackW  out  1  toggles once per completed write
pcIn  in  DATA_W  PC update from fetch
pcWe  in  1  load pcIn into r15 this cycle
pcOut  out  DATA_W  current r15
cpsrIn  in  DATA_W  CPSR update from execute
cpsrWe  in  1  load cpsrIn this cycle
cpsrOut  out  DATA_W  current CPSR

Behaviour:
- Reset (reset=0, asynchronous): all registers 0, CPSR=CPSR_RESET, dataOut=0, readyOut=0, ackW=0. Synchroniser flops and edge-history flops clear to 0, so the first request must be a 0→1 toggle. Pending flags clear, FSM=IDLE. Reset mid-operation aborts any request with no readyOut or ackW.
- Trigger detection: SYNC_STAGES flops, then an XOR with a history flop gives a 1-cycle event (evR, evW).
- Read FSM:
  - IDLE: on evR or pendR, capture addrr[3:0], go to LOOK.
  - LOOK: read the array and register the result into dataOut; go to RESP.
  - RESP: readyOut=1 for exactly this cycle; go to IDLE.
  - Read latency: event to readyOut = 2 cycles; toggle to readyOut = SYNC_STAGES+2 cycles.
  - evR outside IDLE sets pendR (one deep). A third event while pendR=1 is dropped. Protocol rule: a requester must not re-toggle before it sees readyOut.
- Write path (no FSM):
  - On evW, write dataIn to reg[addrw[3:0]] on the same edge.
  - ackW toggles on the following cycle.
  - Writes to r0–r14 are unconditional; r0 is not hardwired to 0.
- r15 priority:
  - evW write to r15 beats pcWe in the same cycle (pcWe ignored).
  - pcWe alone loads pcIn.
  - pcOut is combinational from r15.
- CPSR: cpsrWe loads cpsrIn; cpsrOut is registered state.
- Read/write to the same index in the LOOK cycle: governed by the optional feature below.
- Address bits [31:4] are ignored; no error is raised.
- dataOut and readyOut never change outside the LOOK/RESP sequence.

Optional Feature:
REGBANK_FWD_EN
- Defined: if evW hits the same index that LOOK is reading, dataOut takes dataIn (the new value). The same applies to a pcWe hit on r15 with no write pending.
- Undefined: LOOK returns the pre-write array value; the write still lands and is visible to the next read.

Decomposition:
- Package regbank_pkg:
  - DATA_W and NREGS constants.
  - REG_PC=4'd15.
  - CPSR_RESET default.
  - Read FSM state enum {IDLE, LOOK, RESP}.
- Sub-module toggle_sync_edge: parameterised synchroniser plus XOR edge detector with async active-low reset. Instantiated twice (read, write).

Test Plan:
1. Release reset, sample → all regs 0, cpsrOut=32'hD3, readyOut=0, ackW=0.
2. Write r3=32'hE0837006 (toggle triggerInw), then read r3 → ackW toggles at SYNC_STAGES+2 cycles after the write toggle; readyOut pulses 1 cycle at SYNC_STAGES+2 cycles after the read toggle; dataOut=32'hE0837006.
3. Two read toggles 1 cycle apart (r1 then r2, preloaded 32'h11, 32'h22) → two readyOut pulses 3 cycles apart; the pending read samples addrr when it starts, so hold addrr=r2 until the second readyOut; dataOut=32'h22 at the second pulse.
4. Write r15=32'h100 and pcWe with pcIn=32'h200 in the same cycle → pcOut=32'h100.
5. Read r4 (old 32'hAA) with a write r4=32'hBB landing in the LOOK cycle → dataOut=32'hBB with REGBANK_FWD_EN, 32'hAA without; a follow-up read returns 32'hBB in both builds.
6. Assert reset during LOOK → no readyOut; dataOut=0; a subsequent 0→1 toggle is serviced normally.
